// File: rtl/u_mac_pkg.sv
// u_mac_pkg: shared widths, state encoding and saturation helper for the MAC accumulator
package u_mac_pkg;
    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
    function automatic logic [31:0] sat_max(input int w);
        return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/u_sat_add.sv
// u_sat_add: zero-extended accumulate with carry-out, saturating to all ones on overflow
module u_sat_add import u_mac_pkg::*; #(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int PROD_W = DEF_PROD_W
) (
    input  logic [ACC_W-1:0]  a_i,
    input  logic [PROD_W-1:0] b_i,
    input  logic              sat_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);
    logic [ACC_W:0] full;
    always_comb begin
        full  = {1'b0, a_i} + (ACC_W+1)'(b_i);
        ovf_o = full[ACC_W] | sat_i;
        sum_o = ovf_o ? '1 : full[ACC_W-1:0];
    end
endmodule

// File: rtl/u_mac_acc_pipe.sv
// u_mac_acc_pipe: two-stage packet accumulator returning sum, term count and sticky overflow
module u_mac_acc_pipe import u_mac_pkg::*; #(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf,
    output logic              acc_valid,
    input  logic              acc_ready
);
    state_e            state_q, state_d;
    logic              v1_q, v1_d, last1_q, last1_d, ovf_q, ovf_d;
    logic [PROD_W-1:0] prod1_q, prod1_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              add_ovf, xfer, cnt_max;

    u_sat_add #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .a_i(acc_q), .b_i(prod1_q), .sat_i(ovf_q), .sum_o(sum), .ovf_o(add_ovf)
    );

    always_comb begin
        prod_ready = !rst && state_q != HOLD && !(v1_q && last1_q);
        acc_valid  = !rst && state_q == HOLD;
        xfer       = prod_valid && prod_ready;
        cnt_max    = cnt_q == CNT_W'(sat_max(CNT_W));
        v1_d       = xfer;
        last1_d    = xfer && prod_last;
        prod1_d    = xfer ? prod_i : prod1_q;
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (v1_q) begin
            acc_d   = sum;
            cnt_d   = cnt_max ? cnt_q : cnt_q + 1'b1;
            ovf_d   = add_ovf | cnt_max;
            state_d = last1_q ? HOLD : ACCUM;
        end else if (state_q == HOLD && acc_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            prod1_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            prod1_q <= prod1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_count = cnt_q;
    assign acc_ovf   = ovf_q;
endmodule

// File: tb/tb_u_mac_acc_pipe.sv
// tb_u_mac_acc_pipe: scoreboard bench with directed and randomized packets against a packet-level sum model
module tb_u_mac_acc_pipe;
    localparam longint MAXA = 64'hFFFFFF;
    logic clk = 0, rst = 1;
    logic [15:0] prod_i = 0;
    logic prod_valid = 0, prod_last = 0, prod_ready;
    logic [23:0] acc_o;
    logic [7:0] acc_count;
    logic acc_ovf, acc_valid, acc_ready;
    logic rnd_rdy = 0, rnd_bit = 0, man_rdy = 0;
    typedef struct {longint acc; longint cnt; longint ovf;} res_t;
    res_t exp_q[$];
    int n_chk = 0, n_fail = 0;

    assign acc_ready = rnd_rdy ? rnd_bit : man_rdy;
    always #5 clk = ~clk;

    u_mac_acc_pipe dut (
        .clk(clk), .rst(rst), .prod_i(prod_i), .prod_valid(prod_valid), .prod_last(prod_last),
        .prod_ready(prod_ready), .acc_o(acc_o), .acc_count(acc_count), .acc_ovf(acc_ovf),
        .acc_valid(acc_valid), .acc_ready(acc_ready)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input longint sum, input int n);
        res_t r;
        r.ovf = (sum > MAXA || n > 255) ? 1 : 0;
        r.acc = (sum > MAXA || n > 256) ? MAXA : sum;
        r.cnt = (n > 255) ? 255 : n;
        return r;
    endfunction

    task automatic send_term(input logic [15:0] v, input logic l, input int gap);
        bit ok;
        int k;
        repeat (gap) begin
            prod_valid = 0;
            @(posedge clk); #1;
        end
        prod_valid = 1; prod_i = v; prod_last = l;
        k = 0;
        forever begin
            @(negedge clk);
            ok = prod_ready;
            @(posedge clk); #1;
            if (ok) break;
            if (++k > 5000) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        prod_valid = 0;
    endtask

    task automatic send_pkt(input logic [15:0] t[$], input int maxgap);
        longint s = 0;
        foreach (t[i]) begin
            send_term(t[i], i == t.size() - 1, maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
            s += longint'(t[i]);
        end
        exp_q.push_back(model(s, t.size()));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!acc_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wait_valid", acc_valid, 1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom);
    end

    always @(negedge clk) begin
        if (!rst && acc_valid) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                chk("acc_o", acc_o, exp_q[0].acc);
                chk("acc_count", acc_count, exp_q[0].cnt);
                chk("acc_ovf", acc_ovf, exp_q[0].ovf);
                if (acc_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] tq[$];
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prod_ready", prod_ready, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc_o", acc_o, 0);
        chk("rst_acc_count", acc_count, 0);
        chk("rst_acc_ovf", acc_ovf, 0);
        @(posedge clk); #1 rst = 0;

        tq = {};
        tq.push_back(16'h0001); tq.push_back(16'h0002); tq.push_back(16'h4000);
        send_pkt(tq, 0);
        @(negedge clk); chk("lat_cycle1_valid", acc_valid, 0);
        @(negedge clk); chk("lat_cycle2_valid", acc_valid, 1);

        prod_valid = 1; prod_i = 16'hFFFF; prod_last = 1;
        repeat (10) begin
            @(negedge clk);
            chk("hold_prod_ready", prod_ready, 0);
        end
        @(posedge clk); #1 man_rdy = 1;
        tq = {};
        tq.push_back(16'hFFFF);
        send_pkt(tq, 0);
        man_rdy = 0;
        wait_valid();
        @(posedge clk); #1 man_rdy = 1;
        @(posedge clk); #1 man_rdy = 0;
        @(negedge clk);
        chk("post_hs_valid", acc_valid, 0);
        chk("post_hs_ready", prod_ready, 1);

        man_rdy = 1;
        tq = {};
        repeat (257) tq.push_back(16'hFFFF);
        send_pkt(tq, 0);
        tq = {};
        repeat (256) tq.push_back(16'hFFFF);
        send_pkt(tq, 0);

        send_term(16'h0010, 0, 0);
        send_term(16'h0020, 0, 0);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_acc_o", acc_o, 0);
        chk("midrst_acc_count", acc_count, 0);
        chk("midrst_acc_valid", acc_valid, 0);
        chk("midrst_prod_ready", prod_ready, 1);
        @(posedge clk); #1;
        tq = {};
        tq.push_back(16'h0005);
        send_pkt(tq, 0);

        rnd_rdy = 1;
        repeat (100) begin
            tq = {};
            repeat ($urandom_range(1, 6)) tq.push_back(16'($urandom));
            send_pkt(tq, 2);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
